// File: rtl/banco_registradores.sv
// Parametrised register bank: one write-port operation per cycle (load, clear,
// inc, dec, shift, high-part insert) with carry, plus two registered read ports.
module banco_registradores #(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] valor,
  input  logic                habilita,
  input  logic [2:0]          operacao,
  input  logic [ADDR_W-1:0]   endereco_escrita,
  input  logic [ADDR_W-1:0]   endereco_leitura_a,
  input  logic [ADDR_W-1:0]   endereco_leitura_b,
  output logic [WIDTH-1:0]    saida_a,
  output logic [WIDTH-1:0]    saida_b,
  output logic                carry,
  output logic                erro
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOAD      = 3'b001;
  localparam logic [2:0] OP_CLEAR     = 3'b010;
  localparam logic [2:0] OP_INC       = 3'b011;
  localparam logic [2:0] OP_DEC       = 3'b100;
  localparam logic [2:0] OP_SHL       = 3'b101;
  localparam logic [2:0] OP_SHR       = 3'b110;
  localparam logic [2:0] OP_LOAD_HIGH = 3'b111;

  // Full address space views; addresses without a register read as 0.
  logic [WIDTH-1:0] cur_view  [DEPTH];
  logic [WIDTH-1:0] next_view [DEPTH];

  logic             in_range;
  logic             exec;
  logic [WIDTH-1:0] cur_value;
  logic [WIDTH-1:0] high_value;
  logic [WIDTH-1:0] wr_value;
  logic             carry_next;
  logic             carry_reg;
  logic             erro_reg;
  logic [WIDTH-1:0] saida_a_reg;
  logic [WIDTH-1:0] saida_b_reg;

  assign in_range  = {1'b0, endereco_escrita} < (ADDR_W + 1)'(NUM_REGS);
  assign exec      = habilita & in_range;
  assign cur_value = cur_view[endereco_escrita];

  generate
    if (IN_WIDTH == WIDTH) begin : g_high_full
      assign high_value = valor;
    end else begin : g_high_part
      assign high_value = {valor, cur_value[WIDTH-IN_WIDTH-1:0]};
    end
  endgenerate

  always_comb begin
    wr_value   = cur_value;
    carry_next = carry_reg;
    case (operacao)
      OP_NOP:       wr_value = cur_value;
      OP_LOAD:      wr_value = WIDTH'(valor);
      OP_CLEAR:     wr_value = '0;
      OP_INC: begin
        wr_value   = cur_value + WIDTH'(1);
        carry_next = &cur_value;
      end
      OP_DEC: begin
        wr_value   = cur_value - WIDTH'(1);
        carry_next = ~|cur_value;
      end
      OP_SHL: begin
        wr_value   = cur_value << 1;
        carry_next = cur_value[WIDTH-1];
      end
      OP_SHR: begin
        wr_value   = cur_value >> 1;
        carry_next = cur_value[0];
      end
      OP_LOAD_HIGH: wr_value = high_value;
      default:      wr_value = cur_value;
    endcase
    if (!exec) begin
      carry_next = carry_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi < NUM_REGS) begin : g_reg
        logic [WIDTH-1:0] value_reg;
        logic             hit;

        assign hit           = exec && (endereco_escrita == ADDR_W'(gi));
        assign cur_view[gi]  = value_reg;
        assign next_view[gi] = hit ? wr_value : value_reg;

        always_ff @(posedge clock) begin
          if (!reset) begin
            value_reg <= '0;
          end else begin
            value_reg <= next_view[gi];
          end
        end
      end else begin : g_none
        assign cur_view[gi]  = '0;
        assign next_view[gi] = '0;
      end
    end
  endgenerate

  // Reads take the post-edge value, which gives write-through bypass for free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      saida_a_reg <= '0;
      saida_b_reg <= '0;
      carry_reg   <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      saida_a_reg <= next_view[endereco_leitura_a];
      saida_b_reg <= next_view[endereco_leitura_b];
      carry_reg   <= carry_next;
      erro_reg    <= habilita & ~in_range;
    end
  end

  assign saida_a = saida_a_reg;
  assign saida_b = saida_b_reg;
  assign carry   = carry_reg;
  assign erro    = erro_reg;

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: a default 4-register instance and a
// 3-register instance (for out-of-range writes) share the same stimulus.
module tb_banco_registradores;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOAD      = 3'b001;
  localparam logic [2:0] OP_CLEAR     = 3'b010;
  localparam logic [2:0] OP_INC       = 3'b011;
  localparam logic [2:0] OP_DEC       = 3'b100;
  localparam logic [2:0] OP_SHL       = 3'b101;
  localparam logic [2:0] OP_SHR       = 3'b110;
  localparam logic [2:0] OP_LOAD_HIGH = 3'b111;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  valor;
  logic        habilita;
  logic [2:0]  operacao;
  logic [1:0]  endereco_escrita;
  logic [1:0]  endereco_leitura_a;
  logic [1:0]  endereco_leitura_b;

  logic [15:0] saida_a, saida_b, saida_a3, saida_b3;
  logic        carry, erro, carry3, erro3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  banco_registradores u_dut (
    .clock              (clock),
    .reset              (reset),
    .valor              (valor),
    .habilita           (habilita),
    .operacao           (operacao),
    .endereco_escrita   (endereco_escrita),
    .endereco_leitura_a (endereco_leitura_a),
    .endereco_leitura_b (endereco_leitura_b),
    .saida_a            (saida_a),
    .saida_b            (saida_b),
    .carry              (carry),
    .erro               (erro)
  );

  banco_registradores #(.NUM_REGS(3), .ADDR_W(2)) u_dut3 (
    .clock              (clock),
    .reset              (reset),
    .valor              (valor),
    .habilita           (habilita),
    .operacao           (operacao),
    .endereco_escrita   (endereco_escrita),
    .endereco_leitura_a (endereco_leitura_a),
    .endereco_leitura_b (endereco_leitura_b),
    .saida_a            (saida_a3),
    .saida_b            (saida_b3),
    .carry              (carry3),
    .erro               (erro3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic en, input logic [2:0] op, input logic [1:0] wa,
                     input logic [7:0] v, input logic [1:0] ra, input logic [1:0] rb);
    habilita           = en;
    operacao           = op;
    endereco_escrita   = wa;
    valor              = v;
    endereco_leitura_a = ra;
    endereco_leitura_b = rb;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    habilita = 1'b0; operacao = OP_NOP; valor = 8'h00;
    endereco_escrita = 2'd0; endereco_leitura_a = 2'd0; endereco_leitura_b = 2'd0;

    // Reset for two edges, then read every address on both ports.
    tick();
    tick();
    check("rst_a", saida_a, 16'h0000);
    check("rst_carry", {15'b0, carry}, 16'h0000);
    check("rst_erro", {15'b0, erro}, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd(1'b0, OP_NOP, 2'd0, 8'h00, 2'(i), 2'(3 - i));
      check($sformatf("rst_rd_a%0d", i), saida_a, 16'h0000);
      check($sformatf("rst_rd_b%0d", 3 - i), saida_b, 16'h0000);
    end

    // Zero-extended load, then high-part insert.
    cmd(1'b1, OP_LOAD, 2'd1, 8'h41, 2'd1, 2'd1);
    check("load_r1", saida_a, 16'h0041);
    cmd(1'b1, OP_LOAD_HIGH, 2'd1, 8'hA5, 2'd1, 2'd1);
    check("ldh_r1", saida_a, 16'hA541);
    check("ldh_r1_b", saida_b, 16'hA541);

    // Increment wrap and decrement borrow.
    cmd(1'b1, OP_LOAD, 2'd2, 8'hFF, 2'd2, 2'd1);
    check("load_r2", saida_a, 16'h00FF);
    check("hold_r1_b", saida_b, 16'hA541);
    cmd(1'b1, OP_LOAD_HIGH, 2'd2, 8'hFF, 2'd2, 2'd1);
    check("ldh_r2", saida_a, 16'hFFFF);
    cmd(1'b1, OP_INC, 2'd2, 8'h00, 2'd2, 2'd1);
    check("inc_wrap", saida_a, 16'h0000);
    check("inc_carry", {15'b0, carry}, 16'h0001);
    cmd(1'b1, OP_DEC, 2'd2, 8'h00, 2'd2, 2'd1);
    check("dec_borrow", saida_a, 16'hFFFF);
    check("dec_carry1", {15'b0, carry}, 16'h0001);
    cmd(1'b1, OP_DEC, 2'd2, 8'h00, 2'd2, 2'd1);
    check("dec_plain", saida_a, 16'hFFFE);
    check("dec_carry0", {15'b0, carry}, 16'h0000);

    // Shifts on R3 = 0x8001 and carry hold.
    cmd(1'b1, OP_LOAD, 2'd3, 8'h01, 2'd3, 2'd2);
    cmd(1'b1, OP_LOAD_HIGH, 2'd3, 8'h80, 2'd3, 2'd2);
    check("r3_init", saida_a, 16'h8001);
    check("load_keeps_carry", {15'b0, carry}, 16'h0000);
    cmd(1'b1, OP_SHL, 2'd3, 8'h00, 2'd3, 2'd2);
    check("shl", saida_a, 16'h0002);
    check("shl_carry", {15'b0, carry}, 16'h0001);
    cmd(1'b1, OP_SHR, 2'd3, 8'h00, 2'd3, 2'd2);
    check("shr1", saida_a, 16'h0001);
    check("shr1_carry", {15'b0, carry}, 16'h0000);
    cmd(1'b1, OP_SHR, 2'd3, 8'h00, 2'd3, 2'd2);
    check("shr2", saida_a, 16'h0000);
    check("shr2_carry", {15'b0, carry}, 16'h0001);
    cmd(1'b1, OP_NOP, 2'd3, 8'h00, 2'd3, 2'd2);
    check("nop_carry", {15'b0, carry}, 16'h0001);
    check("nop_r3", saida_a, 16'h0000);
    cmd(1'b0, OP_INC, 2'd3, 8'h00, 2'd3, 2'd2);
    check("dis_r3", saida_a, 16'h0000);
    check("dis_carry", {15'b0, carry}, 16'h0001);
    check("dis_r2_b", saida_b, 16'hFFFE);
    check("erro_inrange", {15'b0, erro}, 16'h0000);

    // Bypass: write and read R0 on both ports in the same cycle.
    cmd(1'b1, OP_LOAD, 2'd0, 8'h12, 2'd0, 2'd0);
    check("bypass_a", saida_a, 16'h0012);
    check("bypass_b", saida_b, 16'h0012);
    cmd(1'b1, OP_CLEAR, 2'd0, 8'h00, 2'd0, 2'd1);
    check("clear_r0", saida_a, 16'h0000);
    cmd(1'b1, OP_LOAD, 2'd0, 8'h12, 2'd2, 2'd0);
    check("reload_r0", saida_b, 16'h0012);

    // Out-of-range write on the 3-register instance (R3 writes never took effect there).
    cmd(1'b1, OP_INC, 2'd3, 8'h00, 2'd3, 2'd2);
    check("oor_erro", {15'b0, erro3}, 16'h0001);
    check("oor_rd3", saida_a3, 16'h0000);
    check("oor_r2", saida_b3, 16'hFFFE);
    check("oor_carry", {15'b0, carry3}, 16'h0000);
    cmd(1'b0, OP_NOP, 2'd0, 8'h00, 2'd0, 2'd1);
    check("oor_erro_pulse", {15'b0, erro3}, 16'h0000);
    check("oor_r0", saida_a3, 16'h0012);
    check("oor_r1", saida_b3, 16'hA541);
    cmd(1'b1, OP_NOP, 2'd3, 8'h00, 2'd0, 2'd1);
    check("oor_nop_erro", {15'b0, erro3}, 16'h0001);

    // Reset in the same cycle as a load: the load is discarded.
    reset = 1'b0;
    cmd(1'b1, OP_LOAD, 2'd0, 8'h55, 2'd0, 2'd0);
    check("mid_rst_a", saida_a, 16'h0000);
    check("mid_rst_carry", {15'b0, carry}, 16'h0000);
    check("mid_rst_erro3", {15'b0, erro3}, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd(1'b0, OP_NOP, 2'd0, 8'h00, 2'(i), 2'(i));
      check($sformatf("post_rst_r%0d", i), saida_a, 16'h0000);
      check($sformatf("post_rst3_r%0d", i), saida_b3, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/banco_registradores.md
# banco_registradores

Parametrised register bank that replaces the single load-only register in the datapath. It holds NUM_REGS registers of WIDTH bits and accepts narrow IN_WIDTH-bit input with zero extension or high-part insertion. One write-port operation runs per cycle: load, clear, increment, decrement or shift, with a carry flag. Two registered read ports with write-through bypass feed the downstream ALU and display logic.

## Interface
- WIDTH, 16, register and read-port width.
- IN_WIDTH, 8, input data width; legal range 1 ≤ IN_WIDTH ≤ WIDTH.
- NUM_REGS, 4, number of registers; legal range ≥ 2.
- ADDR_W, 2, address width; must equal ceil(log2(NUM_REGS)).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- valor  input  IN_WIDTH  write data.
- habilita  input  1  write-port enable; when 0 the operation is a NOP.
- operacao  input  3  write-port operation code; codes are listed under Operation.
- endereco_escrita  input  ADDR_W  target register.
- endereco_leitura_a  input  ADDR_W  read port A address.
- endereco_leitura_b  input  ADDR_W  read port B address.
- saida_a  output  WIDTH  registered read data for port A.
- saida_b  output  WIDTH  registered read data for port B.
- carry  output  1  carry/borrow/shift-out flag.
- erro  output  1  one-cycle pulse: write addressed a nonexistent register.

## Operation
- **Reset.** reset=0 at an edge clears all registers, saida_a, saida_b, carry and erro to 0. Reset has priority over every other input, including a write in the same cycle.
- **Operation codes.** These apply when habilita=1 and endereco_escrita < NUM_REGS. R is the target register.
  - 000 NOP: R unchanged.
  - 001 LOAD: R ← zero-extended valor.
  - 010 CLEAR: R ← 0.
  - 011 INC: R ← R+1, modulo 2^WIDTH. carry ← 1 if R was all ones, else 0.
  - 100 DEC: R ← R−1, modulo 2^WIDTH. carry ← 1 if R was 0 (borrow), else 0.
  - 101 SHL: R ← R shifted left, 0 into the LSB. carry ← old MSB.
  - 110 SHR: R ← R shifted right logically, 0 into the MSB. carry ← old LSB.
  - 111 LOAD_HIGH: the top IN_WIDTH bits of R ← valor; the lower WIDTH−IN_WIDTH bits are unchanged. When IN_WIDTH=WIDTH this behaves as LOAD.
- **carry** changes only on an executed INC/DEC/SHL/SHR. All other cycles hold its value.
- **Out-of-range write.** habilita=1, any operacao (including NOP), and endereco_escrita ≥ NUM_REGS: no register changes, carry holds, and erro=1 for exactly the following cycle. erro=0 in every other case.
- **Reads.** Each edge, saida_x ← the post-edge value of the register at endereco_leitura_x.
  - Write-through bypass: if that register is written in the same cycle, the new value is returned, not the old one.
  - An out-of-range read address returns 0.
- A and B may address the same register or the write target at the same time. No conflicts arise.

## Timing
- Write latency: the register is updated at the edge that samples the command.
- Read latency: 1 cycle. Addresses sampled at edge k produce output valid after edge k, reflecting all writes up to and including edge k.
- One write per cycle. Back-to-back operations on the same register chain: each uses the value produced by the previous edge.
- Reset asserted mid-sequence: the state is cleared at that edge. Commands presented in that cycle are discarded, and operation resumes at the first edge with reset=1.
- Outputs are driven from flops only. There is no combinational path from inputs to outputs.

## Test plan
- **Reset clears state:** hold reset=0 for 2 edges, then with reset=1 read every address on A and B → all reads 0, carry=0, erro=0.
- **Zero-extended load and high-part insert:** LOAD 0x41 into R1, then LOAD_HIGH 0xA5 into R1, reading A=1 each cycle → saida_a=0x0041, then 0xA541.
- **Increment wrap:** LOAD 0xFF into R2, LOAD_HIGH 0xFF into R2, then INC R2 → R2=0x0000, carry=1. Then DEC R2 → R2=0xFFFF, carry=1. Then DEC R2 → R2=0xFFFE, carry=0.
- **Shifts and carry hold:** R3=0x8001. SHL → 0x0002, carry=1. SHR → 0x0001, carry=0. SHR → 0x0000, carry=1. NOP → carry stays 1.
- **Bypass:** in the same cycle, LOAD 0x12 into R0 with A=0 and B=0 → after that edge saida_a=saida_b=0x0012. A new R0 value is never delayed by an extra cycle.
- **Out-of-range and mid-sequence reset:** with NUM_REGS=3, ADDR_W=2, write to address 3 → no register changes, erro=1 for one cycle, and a read of address 3 returns 0. Then assert reset=0 in the same cycle as a LOAD → the load is discarded and all registers are 0.
